// File: rtl/cplx_stream_pkg.sv
// Shared types and constants for the complex-sample stream player.
package cplx_stream_pkg;

  localparam int CPLX_W  = 16;
  localparam int MIN_DIV = 2;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } player_state_t;

endpackage

// File: rtl/cplx_stream_player_strobe_div.sv
// Free-running strobe divider: period max(div,2), new divisor adopted at the wrap.
module strobe_div
  import cplx_stream_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  output logic             strobe,
  output logic             prefetch,
  output logic             wrap
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] d_cur;
  logic [DIV_W-1:0] d_req;

  assign d_req    = (div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div;
  assign wrap     = (cnt == d_cur - DIV_W'(1));
  assign prefetch = (cnt == d_cur - DIV_W'(MIN_DIV));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      d_cur  <= d_req;
      strobe <= 1'b0;
    end else begin
      strobe <= wrap;
      if (wrap) begin
        cnt   <= '0;
        d_cur <= d_req;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/cplx_stream_player.sv
// Preloaded complex-sample source played out at the strobe rate with optional gap.
// Looping is compiled in only when STREAM_PLAYER_LOOP_EN is defined.
module cplx_stream_player
  import cplx_stream_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  div,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_real,
  input  logic [DATA_W-1:0] wr_imag,
  input  logic [ADDR_W:0]   len,
  input  logic [ADDR_W-1:0] gap_at,
  input  logic [DIV_W-1:0]  gap_len,
  input  logic              loop,
  input  logic              start,
  input  logic              stop,
  output logic              strobe,
  output logic              valid_out,
  output logic [DATA_W-1:0] out_real,
  output logic [DATA_W-1:0] out_imag,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

  logic                prefetch;
  logic                wrap;
  player_state_t       state;
  logic [ADDR_W:0]     idx;
  logic [ADDR_W:0]     len_q;
  logic [ADDR_W-1:0]   gap_at_q;
  logic [DIV_W-1:0]    gcnt;
  logic                armed;
  logic                primed;
  logic                stop_pend;
  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [2*DATA_W-1:0] rd_pair_p0;

`ifndef STREAM_PLAYER_LOOP_EN
  logic unused_loop;
  assign unused_loop = loop;
`endif

  strobe_div #(.DIV_W(DIV_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .div      (div),
    .strobe   (strobe),
    .prefetch (prefetch),
    .wrap     (wrap)
  );

  assign busy = (state != IDLE);

  // p0: read-first buffer, prefetched two cycles ahead of the strobe
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {wr_real, wr_imag};
    if (prefetch) rd_pair_p0 <= mem[idx[ADDR_W-1:0]];
  end

  // p1: playback control; outputs update on the edge where strobe rises
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      len_q     <= '0;
      gap_at_q  <= '0;
      gcnt      <= '0;
      armed     <= 1'b0;
      primed    <= 1'b0;
      stop_pend <= 1'b0;
      valid_out <= 1'b0;
      done      <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
    end else begin
      done <= 1'b0;
      // A sample may only be emitted if its prefetch happened while playing.
      if (prefetch) primed <= (state == PLAY);
      if (wrap) primed <= 1'b0;
      if (stop && state != IDLE) stop_pend <= 1'b1;
      case (state)
        IDLE: begin
          stop_pend <= 1'b0;
          if (start && !stop && len != '0) begin
            state    <= PLAY;
            idx      <= '0;
            armed    <= 1'b1;
            len_q    <= len;
            gap_at_q <= gap_at;
          end
        end
        default: begin
          if (wrap) begin
            if (stop_pend) begin
              state     <= IDLE;
              valid_out <= 1'b0;
              stop_pend <= 1'b0;
            end else if (state == GAP) begin
              valid_out <= 1'b0;
              if (gcnt > DIV_W'(2)) gcnt <= gcnt - DIV_W'(1);
              else state <= PLAY;
            end else if (!primed) begin
              valid_out <= 1'b0;
            end else if (idx == len_q) begin
              valid_out <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end else if (armed && idx == {1'b0, gap_at_q} && gap_len != '0) begin
              // The trigger strobe is itself the first gap period.
              armed     <= 1'b0;
              valid_out <= 1'b0;
              if (gap_len != DIV_W'(1)) begin
                state <= GAP;
                gcnt  <= gap_len;
              end
            end else begin
              out_real  <= rd_pair_p0[2*DATA_W-1:DATA_W];
              out_imag  <= rd_pair_p0[DATA_W-1:0];
              valid_out <= 1'b1;
`ifdef STREAM_PLAYER_LOOP_EN
              if (loop && idx == len_q - IDX_ONE) begin
                idx   <= '0;
                armed <= 1'b1;
              end else begin
                idx <= idx + IDX_ONE;
              end
`else
              idx <= idx + IDX_ONE;
`endif
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cplx_stream_player.sv
// Directed bench for cplx_stream_player: reset, pass, gap, loop, abort and edge cases.
module tb_cplx_stream_player;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  div;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [15:0] wr_real;
  logic [15:0] wr_imag;
  logic [10:0] len;
  logic [9:0]  gap_at;
  logic [7:0]  gap_len;
  logic        loop;
  logic        start;
  logic        stop;
  logic        strobe;
  logic        valid_out;
  logic [15:0] out_real;
  logic [15:0] out_imag;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  cplx_stream_player dut (
    .clk(clk), .rst(rst), .div(div), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_real(wr_real), .wr_imag(wr_imag), .len(len), .gap_at(gap_at),
    .gap_len(gap_len), .loop(loop), .start(start), .stop(stop),
    .strobe(strobe), .valid_out(valid_out), .out_real(out_real),
    .out_imag(out_imag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_strobe(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!strobe && n < 300);
    if (!strobe) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no strobe within %0d clks, strobe required", tag, n);
    end
  endtask

  task automatic sync_start();
    wait_strobe("sync_start");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic write_mem(input int addr, input logic [15:0] re, input logic [15:0] im);
    wr_en = 1'b1; wr_addr = 10'(addr); wr_real = re; wr_imag = im;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; div = 8'd20;
    repeat (2) @(negedge clk);
    n_cmp++; if (strobe !== 1'b0) begin n_err++; $display("FAIL rst_strobe: got %b need 0", strobe); end
    n_cmp++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b need 0", valid_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b need 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b need 0", done); end
    n_cmp++; if (out_real !== 16'h0 || out_imag !== 16'h0) begin
      n_err++; $display("FAIL rst_out: got %h/%h need 0000/0000", out_real, out_imag);
    end
    rst = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!strobe && n < 100);
    n_cmp++; if (n != 20) begin n_err++; $display("FAIL first_strobe: got %0d clks need 20", n); end
    n = 0;
    do begin @(negedge clk); n++; end while (!strobe && n < 100);
    n_cmp++; if (n != 20) begin n_err++; $display("FAIL strobe_period20: got %0d clks need 20", n); end
    n_cmp++; if (valid_out !== 1'b0 || out_real !== 16'h0) begin
      n_err++; $display("FAIL idle_outputs: got valid %b real %h need 0/0000", valid_out, out_real);
    end
  endtask

  task automatic test_single_pass();
    len = 11'd8; gap_len = 8'd0; gap_at = 10'd0;
    sync_start();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL pass_busy: got %b need 1", busy); end
    for (int k = 0; k < 8; k++) begin
      wait_strobe("pass_sample");
      n_cmp++;
      if ({valid_out, done, out_real, out_imag} !== {1'b1, 1'b0, 16'(k), ~16'(k)}) begin
        n_err++;
        $display("FAIL pass_sample%0d: got v%b d%b %h/%h need v1 d0 %h/%h",
                 k, valid_out, done, out_real, out_imag, 16'(k), ~16'(k));
      end
    end
    wait_strobe("pass_end");
    n_cmp++; if (valid_out !== 1'b0 || done !== 1'b1) begin
      n_err++; $display("FAIL pass_done: got valid %b done %b need 0/1", valid_out, done);
    end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL pass_idle: got done %b busy %b need 0/0", done, busy);
    end
  endtask

  task automatic test_gap();
    int  exp_r [10] = '{0, 1, 2, 2, 2, 3, 4, 5, 6, 7};
    bit  exp_v [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
    len = 11'd8; gap_at = 10'd3; gap_len = 8'd2;
    sync_start();
    for (int k = 0; k < 10; k++) begin
      wait_strobe("gap_strobe");
      n_cmp++;
      if (valid_out !== exp_v[k] || out_real !== 16'(exp_r[k]) || done !== 1'b0) begin
        n_err++;
        $display("FAIL gap_strobe%0d: got v%b d%b real %h need v%b d0 real %h",
                 k, valid_out, done, out_real, exp_v[k], 16'(exp_r[k]));
      end
    end
    wait_strobe("gap_end");
    n_cmp++; if (valid_out !== 1'b0 || done !== 1'b1) begin
      n_err++; $display("FAIL gap_done: got valid %b done %b need 0/1", valid_out, done);
    end
    gap_len = 8'd0;
  endtask

  task automatic test_loop();
    len = 11'd4; loop = 1'b1;
    sync_start();
`ifdef STREAM_PLAYER_LOOP_EN
    for (int k = 0; k < 10; k++) begin
      wait_strobe("loop_sample");
      n_cmp++;
      if (valid_out !== 1'b1 || out_real !== 16'(k % 4) || done !== 1'b0) begin
        n_err++;
        $display("FAIL loop_sample%0d: got v%b d%b real %h need v1 d0 real %h",
                 k, valid_out, done, out_real, 16'(k % 4));
      end
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_strobe("loop_stop");
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || valid_out !== 1'b0) begin
      n_err++; $display("FAIL loop_stop: got busy %b done %b valid %b need 0/0/0", busy, done, valid_out);
    end
`else
    for (int k = 0; k < 4; k++) begin
      wait_strobe("noloop_sample");
      n_cmp++;
      if (valid_out !== 1'b1 || out_real !== 16'(k)) begin
        n_err++;
        $display("FAIL noloop_sample%0d: got v%b real %h need v1 real %h", k, valid_out, out_real, 16'(k));
      end
    end
    wait_strobe("noloop_end");
    n_cmp++; if (valid_out !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL noloop_done: got valid %b done %b busy %b need 0/1/0", valid_out, done, busy);
    end
`endif
    loop = 1'b0;
  endtask

  task automatic test_abort();
    len = 11'd8;
    sync_start();
    repeat (3) wait_strobe("abort_lead");
    n_cmp++; if (out_real !== 16'd2 || valid_out !== 1'b1) begin
      n_err++; $display("FAIL abort_lead: got v%b real %h need v1 real 0002", valid_out, out_real);
    end
    stop = 1'b1; start = 1'b1;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    wait_strobe("abort");
    n_cmp++; if (valid_out !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL abort_effect: got valid %b done %b busy %b need 0/0/0", valid_out, done, busy);
    end
    n_cmp++; if (out_real !== 16'd2) begin
      n_err++; $display("FAIL abort_hold: got real %h need 0002", out_real);
    end
    sync_start();
    wait_strobe("replay");
    n_cmp++; if (valid_out !== 1'b1 || out_real !== 16'd0 || out_imag !== 16'hFFFF) begin
      n_err++; $display("FAIL replay_first: got v%b %h/%h need v1 0000/ffff", valid_out, out_real, out_imag);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_strobe("replay_stop");
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL replay_stop: got busy %b need 0", busy); end
  endtask

  task automatic test_div_min();
    int n;
    bit exp_v [4] = '{0, 1, 1, 0};
    int exp_r [4] = '{0, 0, 1, 1};
    bit exp_d [4] = '{0, 0, 0, 1};
    div = 8'd1;
    repeat (3) wait_strobe("div1_settle");
    n = 0;
    do begin @(negedge clk); n++; end while (!strobe && n < 100);
    n_cmp++; if (n != 2) begin n_err++; $display("FAIL div1_period: got %0d clks need 2", n); end
    len = 11'd2;
    sync_start();
    for (int k = 0; k < 4; k++) begin
      wait_strobe("div1_strobe");
      n_cmp++;
      if (valid_out !== exp_v[k] || done !== exp_d[k] || out_real !== 16'(exp_r[k])) begin
        n_err++;
        $display("FAIL div1_strobe%0d: got v%b d%b real %h need v%b d%b real %h",
                 k, valid_out, done, out_real, exp_v[k], exp_d[k], 16'(exp_r[k]));
      end
    end
    div = 8'd4;
    repeat (2) wait_strobe("div4_settle");
  endtask

  task automatic test_len_zero();
    len = 11'd0;
    sync_start();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL len0_busy: got %b need 0", busy); end
    wait_strobe("len0");
    n_cmp++; if (valid_out !== 1'b0 || done !== 1'b0) begin
      n_err++; $display("FAIL len0_out: got valid %b done %b need 0/0", valid_out, done);
    end
  endtask

  task automatic test_reset_mid_play();
    len = 11'd8;
    sync_start();
    repeat (2) wait_strobe("midrst_lead");
    n_cmp++; if (out_real !== 16'd1 || valid_out !== 1'b1) begin
      n_err++; $display("FAIL midrst_lead: got v%b real %h need v1 real 0001", valid_out, out_real);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({strobe, valid_out, busy, done, out_real, out_imag} !== {4'b0000, 16'h0, 16'h0}) begin
      n_err++;
      $display("FAIL midrst_zero: got s%b v%b b%b d%b %h/%h need all zero",
               strobe, valid_out, busy, done, out_real, out_imag);
    end
    rst = 1'b0;
    repeat (2) wait_strobe("midrst_after");
    n_cmp++; if (busy !== 1'b0 || valid_out !== 1'b0) begin
      n_err++; $display("FAIL midrst_idle: got busy %b valid %b need 0/0", busy, valid_out);
    end
  endtask

  initial begin
    rst = 1'b1; div = 8'd20; wr_en = 1'b0; wr_addr = '0; wr_real = '0; wr_imag = '0;
    len = '0; gap_at = '0; gap_len = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    test_reset();
    for (int k = 0; k < 8; k++) write_mem(k, 16'(k), ~16'(k));
    div = 8'd4;
    repeat (2) wait_strobe("div4_init");
    test_single_pass();
    test_gap();
    test_loop();
    test_abort();
    test_div_min();
    test_len_zero();
    test_reset_mid_play();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
